// File: rtl/change_dispenser.sv
// Change dispenser: computes paid - price and pays it out as 10/5/2 coins
// through a held request / acknowledge exchange with the coin mechanism.
module change_dispenser #(
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] amount_paid,
  input  logic [7:0] price_total,
  input  logic       coin_ack,
  output logic       coin_valid,
  output logic [3:0] coin_value,
  output logic [7:0] change_left,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [2:0] fsm_state
);

  // Coin handshake: coin_valid/coin_value are raised together and held
  // unchanged until coin_ack is sampled high on a rising edge; that edge
  // completes the transfer and drops coin_valid. coin_ack is ignored while
  // coin_valid is low.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    ISSUE    = 3'd2,
    WAIT_ACK = 3'd3,
    DONE     = 3'd4,
    ERROR    = 3'd5
  } state_t;

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(ACK_TIMEOUT - 1);

  state_t        state;
  logic [7:0]    paid_q;
  logic [7:0]    price_q;
  logic [CW-1:0] wait_cnt;

  logic [7:0] diff;
  logic [7:0] after_ten;
  logic [7:0] after_ack;
  logic [3:0] next_coin;

  assign fsm_state = state;

  // Remainders of 1 or 3 cannot be paid with 2/5/10 coins, so the 10 is
  // skipped when it would leave one, and odd amounts shed a 5 first.
  always_comb begin
    diff      = paid_q - price_q;
    after_ten = change_left - 8'd10;
    after_ack = change_left - {4'd0, coin_value};
    next_coin = 4'd2;
    if (change_left >= 8'd10 && after_ten != 8'd1 && after_ten != 8'd3)
      next_coin = 4'd10;
    else if (change_left[0] && change_left >= 8'd5)
      next_coin = 4'd5;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      paid_q      <= 8'd0;
      price_q     <= 8'd0;
      wait_cnt    <= '0;
      coin_valid  <= 1'b0;
      coin_value  <= 4'd0;
      change_left <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= 2'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            paid_q  <= amount_paid;
            price_q <= price_total;
            busy    <= 1'b1;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (paid_q < price_q) begin
            error    <= 1'b1;
            err_code <= 2'd1;
            state    <= ERROR;
          end else if (diff == 8'd1 || diff == 8'd3) begin
            error    <= 1'b1;
            err_code <= 2'd2;
            state    <= ERROR;
          end else if (diff == 8'd0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            change_left <= diff;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          coin_value <= next_coin;
          coin_valid <= 1'b1;
          wait_cnt   <= '0;
          state      <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (coin_ack) begin
            coin_valid  <= 1'b0;
            change_left <= after_ack;
            if (after_ack == 8'd0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= ISSUE;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            coin_valid <= 1'b0;
            error      <= 1'b1;
            err_code   <= 2'd3;
            state      <= ERROR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          change_left <= 8'd0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        ERROR: begin
          // start only acknowledges the fault; it does not begin a new sale
          if (start) begin
            error       <= 1'b0;
            err_code    <= 2'd0;
            change_left <= 8'd0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: payouts, error paths, ack timeout,
// asynchronous reset mid-transfer and start handling while busy.
module tb_change_dispenser;

  localparam int TO = 20;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] amount_paid;
  logic [7:0] price_total;
  logic       coin_ack;
  logic       coin_valid;
  logic [3:0] coin_value;
  logic [7:0] change_left;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;
  logic [2:0] fsm_state;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  change_dispenser #(.ACK_TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .amount_paid (amount_paid),
    .price_total (price_total),
    .coin_ack    (coin_ack),
    .coin_valid  (coin_valid),
    .coin_value  (coin_value),
    .change_left (change_left),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_code    (err_code),
    .fsm_state   (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic start_txn(input logic [7:0] paid, input logic [7:0] price);
    @(posedge clk); #1;
    amount_paid = paid;
    price_total = price;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_coin(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!coin_valid && cycles < 60);
  endtask

  // Acknowledges every coin ack_delay cycles after it appears and tracks
  // the remaining change against the expected coin list.
  task automatic serve(input int ack_delay, input logic [7:0] rem_start);
    logic [7:0] rem;
    logic [3:0] c;
    int cyc;
    bit first;
    rem = rem_start;
    first = 1'b1;
    while (exp_q.size() > 0) begin
      wait_coin(cyc);
      if (!coin_valid) begin
        check("coin_wait", 32'(coin_valid), 32'd1);
        exp_q.delete();
        return;
      end
      if (first) check("latency", 32'(cyc), 32'd3);
      first = 1'b0;
      c = exp_q.pop_front();
      check("coin_value", 32'(coin_value), 32'(c));
      repeat (ack_delay) @(negedge clk);
      check("coin_hold", 32'({coin_valid, coin_value}), 32'({1'b1, c}));
      @(posedge clk); #1 coin_ack = 1'b1;
      @(posedge clk); #1 coin_ack = 1'b0;
      @(negedge clk);
      rem = rem - {4'd0, c};
      check("coin_drop", 32'(coin_valid), 32'd0);
      check("change_left", 32'(change_left), 32'(rem));
    end
  endtask

  task automatic finish_ok(input string tag);
    check({tag, "_done"}, 32'(done), 32'd1);
    @(negedge clk);
    check({tag, "_done_end"}, 32'({done, busy, change_left}), 32'd0);
  endtask

  task automatic clear_error(input string tag);
    start_txn(8'd0, 8'd0);
    @(negedge clk);
    check({tag, "_clr"}, 32'({error, err_code, busy}), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_clr_idle"}, 32'({busy, coin_valid}), 32'd0);
  endtask

  initial begin
    int cyc;
    int k;
    reset = 1'b1;
    start = 1'b0;
    amount_paid = 8'd0;
    price_total = 8'd0;
    coin_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", 32'({coin_valid, coin_value, change_left, busy, done, error, err_code}), 32'd0);
    #1 reset = 1'b0;

    // 20 - 12 = 8 -> 2,2,2,2
    exp_q = '{4'd2, 4'd2, 4'd2, 4'd2};
    start_txn(8'd20, 8'd12);
    serve(2, 8'd8);
    finish_ok("t8");

    // 15 -> 10,5
    exp_q = '{4'd10, 4'd5};
    start_txn(8'd30, 8'd15);
    serve(1, 8'd15);
    finish_ok("t15");

    // 13 -> 5,2,2,2,2 (10 would strand 3)
    exp_q = '{4'd5, 4'd2, 4'd2, 4'd2, 4'd2};
    start_txn(8'd30, 8'd17);
    serve(0, 8'd13);
    finish_ok("t13");

    // underpaid
    start_txn(8'd10, 8'd12);
    @(negedge clk);
    check("under_busy", 32'({busy, error}), 32'b10);
    @(negedge clk);
    check("under_err", 32'({error, err_code, coin_valid}), 32'b1010);
    repeat (5) @(negedge clk);
    check("under_hold", 32'({error, err_code, coin_valid, busy}), 32'b10101);
    clear_error("under");

    // unmakeable change of 1
    start_txn(8'd13, 8'd12);
    repeat (2) @(negedge clk);
    check("unmake_err", 32'({error, err_code, coin_valid}), 32'b1100);
    clear_error("unmake");

    // ack never arrives
    start_txn(8'd20, 8'd10);
    wait_coin(cyc);
    check("to_coin", 32'({coin_valid, coin_value}), 32'({1'b1, 4'd10}));
    k = 0;
    while (!error && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("to_cycles", 32'(k), 32'(TO));
    check("to_err", 32'({error, err_code, coin_valid}), 32'b1110);
    check("to_left", 32'(change_left), 32'd10);
    @(posedge clk); #1 coin_ack = 1'b1;
    repeat (3) @(posedge clk); #1 coin_ack = 1'b0;
    @(negedge clk);
    check("to_frozen", 32'({error, err_code, change_left}), 32'({1'b1, 2'd3, 8'd10}));
    clear_error("to");

    // zero change, with a second start while busy
    @(posedge clk); #1;
    amount_paid = 8'd12;
    price_total = 8'd12;
    start = 1'b1;
    @(posedge clk); #1;
    amount_paid = 8'd20;
    price_total = 8'd10;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done", 32'({done, change_left, coin_valid}), 32'({1'b1, 8'd0, 1'b0}));
    @(negedge clk);
    check("zero_end", 32'({done, busy}), 32'd0);
    repeat (3) @(negedge clk);
    check("zero_no_restart", 32'({busy, coin_valid}), 32'd0);

    // reset during WAIT_ACK with 6 left
    start_txn(8'd16, 8'd10);
    wait_coin(cyc);
    check("mid_state", 32'({coin_valid, coin_value, change_left}), 32'({1'b1, 4'd2, 8'd6}));
    #2 reset = 1'b1;
    #1;
    check("mid_rst", 32'({coin_valid, coin_value, change_left, busy, done, error, err_code}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1 coin_ack = 1'b1;
    repeat (4) @(posedge clk); #1 coin_ack = 1'b0;
    @(negedge clk);
    check("mid_after", 32'({busy, coin_valid, change_left, done}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
